// File: rtl/xnor_conv_scheduler_if.sv
// ---------------------------------------------------------------------------
// xnor_conv_scheduler_if
// Bundles the layer-sequencer config, the core feedback and every control
// output of the XNOR conv scheduler.
//   master : the scheduler. It takes cfg_* and core_valid and drives the rest.
//   slave  : the environment, i.e. the layer sequencer, the memories and the core.
// Signals:
//   cfg_start, cfg_num_ch_in, cfg_num_ch_out    layer config and start pulse
//   core_valid                                  core output-valid pulse
//   busy, done                                  layer status
//   weight_rd_en/addr, act_rd_en/addr           memory fetch strobes and indices
//   array_start, top_start, top_control,
//   side_control                                array control vectors
//   first_channel, last_channel                 psum FIFO flags
//   start_threshold, threshold_addr             threshold load
// ---------------------------------------------------------------------------
interface xnor_conv_scheduler_if #(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 16
);
  logic              cfg_start;
  logic [CH_W-1:0]   cfg_num_ch_in;
  logic [CH_W-1:0]   cfg_num_ch_out;
  logic              core_valid;
  logic              busy;
  logic              done;
  logic              weight_rd_en;
  logic [ADDR_W-1:0] weight_addr;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic              array_start;
  logic [8:0]        top_start;
  logic [8:0]        top_control;
  logic [8:0]        side_control;
  logic              first_channel;
  logic              last_channel;
  logic              start_threshold;
  logic [CH_W-1:0]   threshold_addr;

  modport master (
    input  cfg_start, cfg_num_ch_in, cfg_num_ch_out, core_valid,
    output busy, done, weight_rd_en, weight_addr, act_rd_en, act_addr,
           array_start, top_start, top_control, side_control,
           first_channel, last_channel, start_threshold, threshold_addr
  );

  modport slave (
    output cfg_start, cfg_num_ch_in, cfg_num_ch_out, core_valid,
    input  busy, done, weight_rd_en, weight_addr, act_rd_en, act_addr,
           array_start, top_start, top_control, side_control,
           first_channel, last_channel, start_threshold, threshold_addr
  );
endinterface

// File: rtl/xnor_conv_scheduler.sv
// ---------------------------------------------------------------------------
// xnor_conv_scheduler
// Walks one XNOR conv core through a whole layer: output channels (outer) x
// input channels (inner). Each pass loads 9 weights, streams IMG_W*IMG_H
// activations while driving the array control vectors, then waits for the
// core to deliver (IMG_W-2)*(IMG_H-2) valid outputs.
// Ports:
//   clk  clock
//   rst  synchronous, active-low reset
//   bus  xnor_conv_scheduler_if.master (config in, core_valid in, all
//        control outputs out; every output is a register)
// ---------------------------------------------------------------------------
module xnor_conv_scheduler #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int CH_W   = 8,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  xnor_conv_scheduler_if.master  bus
);

  localparam int PIX     = IMG_W * IMG_H;
  localparam int OUT_PIX = (IMG_W - 2) * (IMG_H - 2);
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int VC_W    = $clog2(OUT_PIX + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, NEXT, DONE} state_t;

  state_t           state;
  logic [CH_W-1:0]  num_ch_in, num_ch_out;
  logic [CH_W-1:0]  ic, oc;
  logic [3:0]       k;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [VC_W-1:0]  vcount;

  logic [CH_W-1:0]  cin_eff, cout_eff, ic_nx, oc_nx;
  logic             ic_last, oc_last, last_pixel, vc_inc;

  // NOTE: every signal written here gets a value on every path (defaults
  // first), so no latch can be inferred.
  always_comb begin
    cin_eff    = (bus.cfg_num_ch_in  == '0) ? CH_W'(1) : bus.cfg_num_ch_in;
    cout_eff   = (bus.cfg_num_ch_out == '0) ? CH_W'(1) : bus.cfg_num_ch_out;
    ic_last    = (ic == num_ch_in  - CH_W'(1));
    oc_last    = (oc == num_ch_out - CH_W'(1));
    ic_nx      = ic_last ? '0 : ic + CH_W'(1);
    oc_nx      = ic_last ? oc + CH_W'(1) : oc;
    last_pixel = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));
    // Valid pulses only count while the core can be producing this pass.
    vc_inc     = bus.core_valid && (vcount != VC_W'(OUT_PIX)) &&
                 ((state == STREAM) || (state == DRAIN));
  end

  // NOTE: sequential state uses non-blocking assignments only; outputs are
  // computed for the state being entered, so each one is a plain register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      num_ch_in           <= '0;
      num_ch_out          <= '0;
      ic                  <= '0;
      oc                  <= '0;
      k                   <= '0;
      col                 <= '0;
      row                 <= '0;
      vcount              <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.weight_rd_en    <= 1'b0;
      bus.weight_addr     <= '0;
      bus.act_rd_en       <= 1'b0;
      bus.act_addr        <= '0;
      bus.array_start     <= 1'b0;
      bus.top_start       <= '0;
      bus.top_control     <= '0;
      bus.side_control    <= '0;
      bus.first_channel   <= 1'b0;
      bus.last_channel    <= 1'b0;
      bus.start_threshold <= 1'b0;
      bus.threshold_addr  <= '0;
    end else begin
      // Single-cycle pulses default low.
      bus.done            <= 1'b0;
      bus.start_threshold <= 1'b0;
      bus.top_start       <= '0;
      if (vc_inc) vcount <= vcount + VC_W'(1);

      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            state               <= LOAD_W;
            num_ch_in           <= cin_eff;
            num_ch_out          <= cout_eff;
            ic                  <= '0;
            oc                  <= '0;
            k                   <= '0;
            bus.busy            <= 1'b1;
            bus.weight_rd_en    <= 1'b1;
            bus.weight_addr     <= '0;
            bus.first_channel   <= 1'b1;
            bus.last_channel    <= (cin_eff == CH_W'(1));
            bus.start_threshold <= (cin_eff == CH_W'(1));
            bus.threshold_addr  <= '0;
          end
        end

        LOAD_W: begin
          if (k == 4'd8) begin
            state            <= STREAM;
            bus.weight_rd_en <= 1'b0;
            bus.act_rd_en    <= 1'b1;
            bus.array_start  <= 1'b1;
            bus.act_addr     <= ADDR_W'(ic) * ADDR_W'(PIX);
            bus.top_start    <= 9'h1FF;
            bus.top_control  <= 9'h001;
            bus.side_control <= '0;
          end else begin
            k               <= k + 4'd1;
            bus.weight_addr <= bus.weight_addr + ADDR_W'(1);
          end
        end

        STREAM: begin
          if (last_pixel) begin
            state            <= DRAIN;
            bus.act_rd_en    <= 1'b0;
            bus.array_start  <= 1'b0;
            bus.top_control  <= '0;
            bus.side_control <= '0;
          end else begin
            bus.act_addr    <= bus.act_addr + ADDR_W'(1);
            bus.top_control <= {bus.top_control[7:0], bus.top_control[8]};
            if (col == COL_W'(IMG_W - 1)) begin
              col              <= '0;
              row              <= row + ROW_W'(1);
              bus.side_control <= '0;
            end else begin
              col <= col + COL_W'(1);
              // The window below-right is complete once the next pixel
              // sits at row>=2, col>=2.
              bus.side_control <= ((row >= ROW_W'(2)) && (col >= COL_W'(1))) ?
                                  9'h1FF : 9'h000;
            end
          end
        end

        DRAIN: begin
          if (vcount == VC_W'(OUT_PIX)) state <= NEXT;
        end

        NEXT: begin
          vcount <= '0;
          row    <= '0;
          col    <= '0;
          k      <= '0;
          if (ic_last && oc_last) begin
            state             <= DONE;
            bus.done          <= 1'b1;
            bus.first_channel <= 1'b0;
            bus.last_channel  <= 1'b0;
          end else begin
            state               <= LOAD_W;
            ic                  <= ic_nx;
            oc                  <= oc_nx;
            bus.weight_rd_en    <= 1'b1;
            // Pass bases are consecutive multiples of 9, so the weight
            // address simply keeps counting across passes.
            bus.weight_addr     <= bus.weight_addr + ADDR_W'(1);
            bus.first_channel   <= (ic_nx == '0);
            bus.last_channel    <= (ic_nx == num_ch_in - CH_W'(1));
            bus.start_threshold <= (ic_nx == num_ch_in - CH_W'(1));
            bus.threshold_addr  <= oc_nx;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_conv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xnor_conv_scheduler
// Directed bench for xnor_conv_scheduler at IMG_W=IMG_H=4 (16 pixels, 4
// outputs per pass). Inputs change and outputs are sampled 1 ns after the
// rising edge, so each sample window shows the registered values of one
// cycle.
// ---------------------------------------------------------------------------
module tb_xnor_conv_scheduler;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int CH_W    = 8;
  localparam int ADDR_W  = 16;
  localparam int PIX     = IMG_W * IMG_H;
  localparam int OUT_PIX = (IMG_W - 2) * (IMG_H - 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   thr_seen = 0;

  always #5 clk = ~clk;

  xnor_conv_scheduler_if #(.CH_W(CH_W), .ADDR_W(ADDR_W)) bus ();

  xnor_conv_scheduler #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH_W  (CH_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"},
          {31'd0, bus.busy | bus.done | bus.weight_rd_en | bus.act_rd_en |
                  bus.array_start | bus.first_channel | bus.last_channel |
                  bus.start_threshold}, 32'd0);
    check({tag, "_vectors"}, {5'd0, bus.top_start, bus.top_control, bus.side_control}, 32'd0);
    check({tag, "_addrs"}, {bus.weight_addr, bus.act_addr}, 32'd0);
  endtask

  // Pulses cfg_start; returns in the first LOAD_W window.
  task automatic start_layer(input int nin, input int nout);
    check("idle_before_start", {31'd0, bus.busy}, 32'd0);
    bus.cfg_num_ch_in  = CH_W'(nin);
    bus.cfg_num_ch_out = CH_W'(nout);
    bus.cfg_start      = 1'b1;
    tick();
    bus.cfg_start      = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  // Runs one pass starting at its k==0 window; returns in the window after
  // NEXT (next pass k==0, or DONE).
  task automatic run_pass(input int wbase, input int abase, input bit exp_first,
                          input bit exp_last, input int thr_addr, input int n_stream_v,
                          input int n_idle, input bit extra, input bit poke);
    logic [8:0] exp_top;
    logic [8:0] exp_side;
    bit         ok;
    // Weight load
    check("first_channel_load", {31'd0, bus.first_channel}, {31'd0, exp_first});
    check("last_channel_load",  {31'd0, bus.last_channel},  {31'd0, exp_last});
    check("start_threshold_k0", {31'd0, bus.start_threshold}, {31'd0, exp_last});
    if (exp_last) check("threshold_addr", {24'd0, bus.threshold_addr}, thr_addr);
    for (int k = 0; k < 9; k++) begin
      if (bus.start_threshold) thr_seen++;
      check("weight_rd_en", {31'd0, bus.weight_rd_en}, 32'd1);
      check("weight_addr", {16'd0, bus.weight_addr}, wbase + k);
      if (k > 0) check("start_threshold_pulse", {31'd0, bus.start_threshold}, 32'd0);
      if (poke && k == 4) begin
        bus.cfg_num_ch_in  = 8'd3;
        bus.cfg_num_ch_out = 8'd3;
        bus.cfg_start      = 1'b1;
      end
      tick();
      bus.cfg_start = 1'b0;
    end
    // Pixel stream
    for (int p = 0; p < PIX; p++) begin
      if (bus.start_threshold) thr_seen++;
      exp_top  = 9'h001 << (p % 9);
      exp_side = ((p / IMG_W) >= 2 && (p % IMG_W) >= 2) ? 9'h1FF : 9'h000;
      check("stream_strobes", {30'd0, bus.act_rd_en, bus.array_start}, 32'd3);
      check("weight_rd_en_off", {31'd0, bus.weight_rd_en}, 32'd0);
      check("act_addr", {16'd0, bus.act_addr}, abase + p);
      check("top_start", {23'd0, bus.top_start}, (p == 0) ? 32'h1FF : 32'h0);
      check("top_control", {23'd0, bus.top_control}, {23'd0, exp_top});
      check("side_control", {23'd0, bus.side_control}, {23'd0, exp_side});
      bus.core_valid = ((n_stream_v >= 1 && p == 3) || (n_stream_v >= 2 && p == 9));
      if (poke && p == 7) bus.cfg_start = 1'b1;
      tick();
      bus.core_valid = 1'b0;
      bus.cfg_start  = 1'b0;
    end
    check("stream_end_strobes", {30'd0, bus.act_rd_en, bus.array_start}, 32'd0);
    // Drain: an idle stretch must not end the pass on its own.
    ok = 1'b1;
    for (int i = 0; i < n_idle; i++) begin
      if (bus.done || bus.weight_rd_en || bus.act_rd_en) ok = 1'b0;
      tick();
    end
    if (n_idle > 0) check("drain_hold", {31'd0, ok}, 32'd1);
    for (int i = 0; i < OUT_PIX - n_stream_v; i++) begin
      bus.core_valid = 1'b1;
      tick();
      bus.core_valid = 1'b0;
      if (i < OUT_PIX - n_stream_v - 1) tick();
    end
    // Count is full here; an extra pulse must saturate.
    check("drain_wait", {30'd0, bus.weight_rd_en, bus.done}, 32'd0);
    bus.core_valid = extra;
    tick();
    bus.core_valid = 1'b0;
    // NEXT window: flags still describe this pass.
    check("next_flags", {30'd0, bus.first_channel, bus.last_channel},
          {30'd0, exp_first, exp_last});
    check("next_quiet", {29'd0, bus.weight_rd_en, bus.act_rd_en, bus.done}, 32'd0);
    tick();
  endtask

  // Called in the DONE window.
  task automatic finish_layer();
    check("done_pulse", {30'd0, bus.done, bus.busy}, 32'd3);
    check("done_flags_clear", {30'd0, bus.first_channel, bus.last_channel}, 32'd0);
    tick();
    check("after_done", {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bus.cfg_start      = 1'b0;
    bus.cfg_num_ch_in  = '0;
    bus.cfg_num_ch_out = '0;
    bus.core_valid     = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // 1x1 layer, all four valids in DRAIN
    start_layer(1, 1);
    run_pass(0, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    finish_layer();

    // 3 in x 2 out, valids split between STREAM and DRAIN, extra pulse
    // each pass, idle drain on the pass after the first extra pulse.
    thr_seen = 0;
    start_layer(3, 2);
    for (int pass = 0; pass < 6; pass++) begin
      run_pass(9 * pass, (pass % 3) * PIX, (pass % 3) == 0, (pass % 3) == 2,
               pass / 3, 2, (pass == 1) ? 6 : 0, 1'b1, 1'b0);
    end
    finish_layer();
    check("threshold_pulses", thr_seen, 32'd2);

    // Reset in the 5th STREAM cycle
    start_layer(1, 1);
    repeat (9 + 4) tick();
    check("pre_reset_stream", {30'd0, bus.act_rd_en, bus.array_start}, 32'd3);
    rst = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset_idle");
    start_layer(1, 1);
    run_pass(0, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    finish_layer();

    // cfg_start while busy is ignored; exactly one done
    start_layer(1, 1);
    run_pass(0, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    finish_layer();
    ok = 1'b1;
    repeat (20) begin
      if (bus.done || bus.busy) ok = 1'b0;
      tick();
    end
    check("single_done", {31'd0, ok}, 32'd1);

    // Zero channel counts behave as 1x1
    start_layer(0, 0);
    run_pass(0, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    finish_layer();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
